// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst memory master: FSM states,
// access-size encodings, the default memory window and the beat-count decode.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic [31:0] START_ADDR_DEFAULT = 32'h8002_0000;
  localparam int unsigned DEPTH_DEFAULT      = 1048576;

  function automatic logic [4:0] size_beats(input logic [1:0] size);
    case (size)
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_burst_master_if.sv
// Client request/write/read channels plus the memory-side pins of the burst master.
// Handshakes: a request moves on req_valid && req_ready, a write beat on
// wr_valid && wr_ready; rd_valid has no backpressure and must be taken when high.
interface mem_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_rw;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_busy;

  modport master (
    input  req_valid, req_addr, req_size, req_rw, wr_data, wr_valid,
           mem_data_in, mem_busy,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           mem_address, mem_data_out, mem_access_size, mem_rw, mem_enable
  );

  modport slave (
    output req_valid, req_addr, req_size, req_rw, wr_data, wr_valid,
           mem_data_in, mem_busy,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
           mem_address, mem_data_out, mem_access_size, mem_rw, mem_enable
  );
endinterface

// File: rtl/mem_addr_check.sv
// Accepts a burst only if it is word aligned and lies entirely inside the memory
// window; the end address is computed one bit wider so a burst cannot wrap past zero.
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEFAULT,
  parameter int unsigned           DEPTH      = DEPTH_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  output logic                  ok
);
  typedef logic [ADDR_WIDTH:0] wide_t;

  localparam wide_t LIMIT = wide_t'(START_ADDR) + wide_t'(DEPTH) - wide_t'(1);

  wide_t last_byte;

  assign last_byte = wide_t'(addr) + wide_t'({size_beats(size), 2'b00}) - wide_t'(1);
  assign ok = (addr[1:0] == 2'b00) && (addr >= START_ADDR) && (last_byte <= LIMIT);
endmodule

// File: rtl/mem_burst_master.sv
// Burst master: turns one client request into 1/4/8/16 single-word memory accesses,
// paced by wr_valid on writes and one beat per cycle on reads.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = START_ADDR_DEFAULT,
  parameter int unsigned           DEPTH      = DEPTH_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  mem_burst_master_if.master  bus,
  output state_t              dbg_state,
  output logic                dbg_busy_in_burst
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_t     state, state_next;
  addr_t      base_q;
  logic [1:0] size_q;
  logic [4:0] beat, beat_next;
  logic       done_q, done_next;
  logic       err_q, err_next;
  logic       rd_valid_q, rd_last_q;
  logic       accept;
  logic       addr_ok;
  logic       last_beat;

  mem_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .START_ADDR (START_ADDR),
    .DEPTH      (DEPTH)
  ) u_addr_check (
    .addr (bus.req_addr),
    .size (bus.req_size),
    .ok   (addr_ok)
  );

  assign last_beat = (beat == size_beats(size_q) - 5'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      size_q     <= SIZE_1;
      beat       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state      <= state_next;
      beat       <= beat_next;
      done_q     <= done_next;
      err_q      <= err_next;
      // Memory returns read data one cycle after the beat is issued.
      rd_valid_q <= (state == ST_READ);
      rd_last_q  <= (state == ST_READ) && last_beat;
      if (accept) begin
        base_q <= bus.req_addr;
        size_q <= bus.req_size;
      end
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat;
    done_next  = 1'b0;
    err_next   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (addr_ok) begin
            accept     = 1'b1;
            beat_next  = '0;
            state_next = bus.req_rw ? ST_READ : ST_WRITE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (bus.wr_valid) begin
          beat_next = beat + 5'd1;
          if (last_beat) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      ST_READ: begin
        beat_next = beat + 5'd1;
        if (last_beat) state_next = ST_DRAIN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.req_ready       = (state == ST_IDLE);
  assign bus.wr_ready        = (state == ST_WRITE);
  assign bus.rd_data         = bus.mem_data_in;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_last         = rd_last_q;
  assign bus.done            = done_q || (state == ST_DRAIN);
  assign bus.err             = err_q;
  // Address stays at base + 4*beat through write gaps; parked at zero when idle.
  assign bus.mem_address     = (state == ST_WRITE || state == ST_READ)
                               ? base_q + addr_t'({beat, 2'b00}) : '0;
  assign bus.mem_data_out    = (state == ST_WRITE) ? bus.wr_data : {DATA_WIDTH{1'b0}};
  assign bus.mem_access_size = size_q;
  assign bus.mem_rw          = (state != ST_WRITE);
  assign bus.mem_enable      = ((state == ST_WRITE) && bus.wr_valid) || (state == ST_READ);

  assign dbg_state         = state;
  assign dbg_busy_in_burst = bus.mem_busy && (state == ST_WRITE || state == ST_READ);
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a small word memory model and
// negedge monitor that logs every memory access and client-side read beat.
module tb_mem_burst_master;
  import mem_pkg::*;

  localparam logic [31:0] START = 32'h8002_0000;

  logic   clock;
  logic   reset;
  state_t dbg_state;
  logic   dbg_busy_in_burst;

  mem_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_burst_master dut (
    .clock             (clock),
    .reset             (reset),
    .bus               (bus),
    .dbg_state         (dbg_state),
    .dbg_busy_in_burst (dbg_busy_in_burst)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory model (1-cycle read latency) ----------------
  logic [31:0] mem [256];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | i;
      bus.mem_data_in <= '0;
    end else if (bus.mem_enable) begin
      if (!bus.mem_rw) mem[bus.mem_address[9:2]] <= bus.mem_data_out;
      else             bus.mem_data_in <= mem[bus.mem_address[9:2]];
    end
  end

  // ---------------- monitor ----------------
  int          en_cnt, done_cnt, err_cnt, last_cnt, last_pos, hold_cnt, done_last;
  logic [31:0] hold_addr;
  logic [1:0]  sz_seen;
  logic [31:0] wa_q[$], wd_q[$], ra_q[$], rd_q[$];
  logic [31:0] exp_q[$];
  logic        clr;

  always @(negedge clock) begin
    if (clr) begin
      en_cnt = 0; done_cnt = 0; err_cnt = 0; last_cnt = 0; last_pos = -1;
      hold_cnt = 0; done_last = 0; hold_addr = '0; sz_seen = '0;
      wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_q.delete();
    end else begin
      if (bus.mem_enable) begin
        en_cnt++;
        sz_seen = bus.mem_access_size;
        if (!bus.mem_rw) begin
          wa_q.push_back(bus.mem_address);
          wd_q.push_back(bus.mem_data_out);
        end else begin
          ra_q.push_back(bus.mem_address);
        end
      end
      if (bus.wr_ready && !bus.mem_enable) begin
        hold_cnt++;
        hold_addr = bus.mem_address;
      end
      if (bus.rd_valid) begin
        if (bus.rd_last) begin
          last_cnt++;
          last_pos = rd_q.size();
        end
        rd_q.push_back(bus.rd_data);
      end
      if (bus.done) done_cnt++;
      if (bus.done && bus.rd_last) done_last++;
      if (bus.err) err_cnt++;
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clock);
    #1 clr = 1'b0;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [1:0] size, input logic rw);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_rw    = rw;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [1:0] size, input int n,
                             input int gap_at, input logic [31:0] d0);
    send_req(addr, size, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.wr_valid = 1'b0;
        @(posedge clock);
        #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = d0 + i;
      @(posedge clock);
      #1;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock);
      if (bus.done) seen = 1'b1;
      n++;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr           = 1'b0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 2'b00;
    bus.req_rw    = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.mem_busy  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_wr_ready",  64'(bus.wr_ready), 64'd0);
    check("rst_rd_valid",  64'(bus.rd_valid), 64'd0);
    check("rst_rd_last",   64'(bus.rd_last), 64'd0);
    check("rst_done",      64'(bus.done), 64'd0);
    check("rst_err",       64'(bus.err), 64'd0);
    check("rst_mem_en",    64'(bus.mem_enable), 64'd0);
    check("rst_mem_addr",  64'(bus.mem_address), 64'd0);
    check("rst_mem_dout",  64'(bus.mem_data_out), 64'd0);
    check("rst_mem_rw",    64'(bus.mem_rw), 64'd1);
    check("rst_mem_size",  64'(bus.mem_access_size), 64'd0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    @(posedge clock);
    #1 reset = 1'b0;
    clear_logs();

    // single-word write
    write_burst(START, SIZE_1, 1, -1, 32'hDEAD_BEEF);
    @(negedge clock);
    check("w1_done_next", 64'(bus.done), 64'd1);
    repeat (2) @(negedge clock);
    check("w1_en_cnt", 64'(en_cnt), 64'd1);
    check("w1_addr",   64'(wa_q[0]), 64'h8002_0000);
    check("w1_data",   64'(wd_q[0]), 64'hDEAD_BEEF);
    check("w1_no_rd",  64'(ra_q.size()), 64'd0);
    check("w1_done_cnt", 64'(done_cnt), 64'd1);
    clear_logs();

    // 4-word read with mem_busy held high
    bus.mem_busy = 1'b1;
    send_req(32'h8002_0010, SIZE_4, 1'b1);
    wait_done(20, "r4_done_seen");
    bus.mem_busy = 1'b0;
    repeat (2) @(negedge clock);
    check("r4_en_cnt", 64'(en_cnt), 64'd4);
    check("r4_nrd", 64'(rd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h5A00_0004 + i);
    for (int i = 0; i < 4 && i < ra_q.size(); i++)
      check($sformatf("r4_addr%0d", i), 64'(ra_q[i]), 64'(32'h8002_0010 + 4 * i));
    for (int i = 0; i < 4 && i < rd_q.size(); i++)
      check($sformatf("r4_data%0d", i), 64'(rd_q[i]), 64'(exp_q.pop_front()));
    exp_q.delete();
    check("r4_last_cnt", 64'(last_cnt), 64'd1);
    check("r4_last_pos", 64'(last_pos), 64'd3);
    check("r4_done_drain", 64'(done_last), 64'd1);
    check("r4_done_cnt", 64'(done_cnt), 64'd1);
    check("r4_size", 64'(sz_seen), 64'(SIZE_4));
    clear_logs();

    // 8-word write with a wr_valid gap before beat 3
    write_burst(32'h8002_0040, SIZE_8, 8, 3, 32'h1000_0000);
    wait_done(5, "w8_done_seen");
    repeat (2) @(negedge clock);
    check("w8_en_cnt", 64'(en_cnt), 64'd8);
    check("w8_hold_cnt", 64'(hold_cnt), 64'd1);
    check("w8_hold_addr", 64'(hold_addr), 64'h8002_004C);
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      check($sformatf("w8_addr%0d", i), 64'(wa_q[i]), 64'(32'h8002_0040 + 4 * i));
      check($sformatf("w8_data%0d", i), 64'(wd_q[i]), 64'(32'h1000_0000 + i));
    end
    clear_logs();

    // rejected requests: misaligned, below window, running past the top
    send_req(32'h8002_0002, SIZE_1, 1'b0);
    @(negedge clock);
    check("e_misalign_err", 64'(bus.err), 64'd1);
    check("e_misalign_idle", 64'(bus.req_ready), 64'd1);
    @(negedge clock);
    check("e_err_one_cycle", 64'(bus.err), 64'd0);
    send_req(32'h8001_FFFC, SIZE_1, 1'b1);
    @(negedge clock);
    check("e_below_err", 64'(bus.err), 64'd1);
    send_req(32'h8011_FFE0, SIZE_16, 1'b1);
    @(negedge clock);
    check("e_over_err", 64'(bus.err), 64'd1);
    repeat (3) @(negedge clock);
    check("e_no_mem_en", 64'(en_cnt), 64'd0);
    check("e_err_cnt", 64'(err_cnt), 64'd3);
    clear_logs();

    // 16 words ending exactly on the last byte is accepted
    send_req(32'h8011_FFC0, SIZE_16, 1'b1);
    wait_done(30, "top_done_seen");
    repeat (2) @(negedge clock);
    check("top_no_err", 64'(err_cnt), 64'd0);
    check("top_en_cnt", 64'(en_cnt), 64'd16);
    check("top_last_addr", 64'(ra_q[ra_q.size() - 1]), 64'h8011_FFFC);
    clear_logs();

    // reset during beat 5 of a 16-word read
    send_req(32'h8002_0100, SIZE_16, 1'b1);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rr_beat5_addr", 64'(bus.mem_address), 64'h8002_0114);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rr_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("rr_mem_en", 64'(bus.mem_enable), 64'd0);
    check("rr_rd_valid", 64'(bus.rd_valid), 64'd0);
    repeat (5) @(negedge clock);
    check("rr_no_done", 64'(done_cnt), 64'd0);
    check("rr_en_cnt", 64'(en_cnt), 64'd6);
    clear_logs();

    // 16-word write then back-to-back 16-word read of the same words
    write_burst(32'h8002_0200, SIZE_16, 16, -1, 32'hC0DE_0000);
    wait_done(5, "wr16_done_seen");
    send_req(32'h8002_0200, SIZE_16, 1'b1);
    wait_done(30, "rd16_done_seen");
    repeat (2) @(negedge clock);
    check("wr16_nwr", 64'(wa_q.size()), 64'd16);
    check("rd16_nrd", 64'(rd_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hC0DE_0000 + i);
    for (int i = 0; i < 16 && i < rd_q.size(); i++)
      check($sformatf("rd16_data%0d", i), 64'(rd_q[i]), 64'(exp_q.pop_front()));
    check("rd16_last_pos", 64'(last_pos), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter START_ADDR, default 32'h80020000, first valid memory byte address.
REQ-004 SHALL have parameter DEPTH, default 1048576, memory size in bytes.
REQ-005 SHALL have port clock  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_valid  in  1  client burst request strobe.
REQ-008 SHALL have port req_ready  out  1  high when in IDLE; request accepted on req_valid && req_ready.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH  burst start byte address.
REQ-010 SHALL have port req_size  in  2  00=1, 01=4, 10=8, 11=16 words.
REQ-011 SHALL have port req_rw  in  1  1=read, 0=write.
REQ-012 SHALL have port wr_data  in  DATA_WIDTH  client write word.
REQ-013 SHALL have port wr_valid  in  1  wr_data valid.
REQ-014 SHALL have port wr_ready  out  1  high in WRITE state; beat consumed on wr_valid && wr_ready.
REQ-015 SHALL have port rd_data  out  DATA_WIDTH  read word to client.
REQ-016 SHALL have port rd_valid  out  1  rd_data valid; no backpressure.
REQ-017 SHALL have port rd_last  out  1  with rd_valid on final read beat.
REQ-018 SHALL have port done  out  1  one-cycle pulse at burst completion.
REQ-019 SHALL have port err  out  1  one-cycle pulse on rejected request.
REQ-020 SHALL have ports mem_address (ADDR_WIDTH), mem_data_out (DATA_WIDTH), mem_access_size (2), mem_rw (1), mem_enable (1), all out, driving the memory's address, data_in, access_size, rw, enable.
REQ-021 SHALL have ports mem_data_in (DATA_WIDTH, in, memory data_out) and mem_busy (1, in, memory busy; monitored only, never stalls sequencing).

Function
REQ-022 SHALL use states IDLE, WRITE, READ, DRAIN; IDLE->WRITE/READ on accepted valid request, else IDLE.
REQ-023 SHALL latch req_addr, req_size, req_rw on acceptance; beat count N = 1/4/8/16; 5-bit beat counter cleared.
REQ-024 SHALL reject (err pulse next cycle, stay IDLE, no mem_enable) if req_addr[1:0]!=0, req_addr<START_ADDR, or req_addr+4*N-1 > START_ADDR+DEPTH-1 (33-bit compare, no wrap).
REQ-025 SHALL drive mem_address = base + 4*beat, mem_access_size = latched size, for every beat.
REQ-026 WRITE: each cycle with wr_valid, SHALL assert mem_enable=1, mem_rw=0, mem_data_out=wr_data, and increment beat; without wr_valid SHALL deassert mem_enable and hold mem_address.
REQ-027 WRITE: after beat N-1 accepted, SHALL pulse done next cycle and return to IDLE.
REQ-028 READ: SHALL issue one beat per cycle (mem_enable=1, mem_rw=1), N consecutive cycles, then enter DRAIN.
REQ-029 SHALL present rd_data = mem_data_in with rd_valid=1 in the cycle after each issued read beat (1-cycle latency); rd_last on beat N-1.
REQ-030 DRAIN: SHALL last one cycle (final rd_valid), pulse done that cycle, then IDLE.
REQ-031 SHALL keep mem_enable=0 in IDLE and DRAIN; req_valid outside IDLE ignored.
REQ-032 SHALL treat wr_valid outside WRITE as ignored.

Reset
REQ-033 SHALL, on reset, enter IDLE; req_ready=1; wr_ready, rd_valid, rd_last, done, err, mem_enable = 0; mem_address, mem_data_out = 0; mem_rw=1; mem_access_size=00.
REQ-034 SHALL abandon any partial burst on reset mid-operation; no done, no further mem_enable.

Structure
REQ-035 SHALL take state encoding, access-size encodings, START_ADDR and DEPTH defaults from shared package mem_pkg.
REQ-036 SHALL place the range/alignment check in one sub-module mem_addr_check.

Verification
REQ-037 Single-word write 32'hDEADBEEF to 32'h80020000 -> one mem_enable cycle, mem_rw=0, done next cycle.
REQ-038 4-word read at 32'h80020010 -> mem_address 0x10,0x14,0x18,0x1C offsets on 4 cycles; 4 rd_valid, rd_last on 4th; done in DRAIN.
REQ-039 8-word write with wr_valid low on beat 3 -> mem_enable low that cycle, address held, 8 total writes.
REQ-040 Requests at 32'h80020002, 32'h8001FFFC, and 16 words at START_ADDR+DEPTH-32 -> err pulse each, no mem_enable.
REQ-041 Reset asserted during beat 5 of 16-word read -> next cycle IDLE, mem_enable=0, no done.
REQ-042 Write-then-read 16 words back-to-back -> read data equals written data.
